lsq_mem_ctrl: RTL and testbench
===============================

Name: lsq_mem_ctrl

Overview:
Sequencer between the load/store queue and the data-memory port. Pops one ld/st entry at a time from the LSQ and computes the effective address and byte masks. Runs a single request/response transaction on dmem, formats load data, and broadcasts completion on the CDB. It also makes in-flight memory transactions safe against pipeline flush.

Parameters:
PREG_W, 6, physical register index width ($clog2(NUM_REGS))
ROB_W, 5, ROB index width ($clog2(ROB_SIZE))

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
flush  in  1  pipeline flush (mispredict)
lsq_read_en  out  1  pop request to LSQ
lsq_valid  in  1  LSQ entry valid this cycle (registered response to lsq_read_en)
lsq_opcode  in  7  op_b_load / op_b_store
lsq_funct3  in  3  size/sign
lsq_imm  in  32  offset
lsq_phys_rd  in  PREG_W  load destination
lsq_rob_idx  in  ROB_W  ROB entry
rs1_val  in  32  base register value, valid with lsq_valid
rs2_val  in  32  store data, valid with lsq_valid
dmem_addr  out  32  word-aligned address
dmem_rmask  out  4  read byte mask
dmem_wmask  out  4  write byte mask
dmem_wdata  out  32  shifted store data
dmem_rdata  in  32  read data
dmem_resp  in  1  transaction done
cdb_valid  out  1  completion pulse
cdb_phys_rd  out  PREG_W  0 for stores
cdb_rob_idx  out  ROB_W  completing ROB entry
cdb_data  out  32  load result; 0 for stores
cdb_misaligned  out  1  address-misaligned exception flag
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; captured entry cleared.
- States: IDLE, POLL, ISSUE, WAIT, DONE, DRAIN.
- IDLE: lsq_read_en=1 for exactly that cycle (only when flush=0). Go to POLL.
- POLL: lsq_read_en=0. If lsq_valid, capture entry and compute addr=rs1_val+lsq_imm (mod 2^32), off=addr[1:0]. Go to DONE with cdb_misaligned=1 when misaligned, else ISSUE. If not lsq_valid, go back to IDLE. lsq_read_en is never high in two consecutive cycles, so the LSQ never double-pops.
- Misaligned: halfword with off[0]=1, or word with off!=0. No dmem access.
- Masks: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111. Loads drive only rmask; stores drive only wmask with wdata=rs2_val<<(8*off).
- ISSUE: dmem_addr={addr[31:2],2'b00} and the mask are driven for exactly 1 cycle, then go to WAIT. Masks are 0 in every other state.
- WAIT: hold until dmem_resp=1. Loads: extract the byte/half at off; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through. Go to DONE.
- DONE: cdb_valid=1 for one cycle with captured rd/rob_idx/data. Stores report phys_rd=0 and data=0. Go to IDLE.
- Minimum latency, lsq_valid to cdb_valid: 3 cycles plus the dmem response wait.
- flush in IDLE/POLL/ISSUE/DONE: next state IDLE. Any lsq_valid is discarded, no CDB, and a pending ISSUE is not driven. If ISSUE is already being driven, treat it as WAIT (go to DRAIN).
- flush in WAIT: go to DRAIN. DRAIN waits for dmem_resp, discards the data, produces no CDB, then goes to IDLE. dmem is never abandoned mid-transaction.
- flush while in DRAIN: no effect.
- dmem_resp outside WAIT/DRAIN: ignored.

Test Plan:
- LW: rs1=0x1000, imm=4, dmem_resp 3 cycles after ISSUE, rdata=0xDEADBEEF -> dmem_addr=0x1004, rmask=1111, single cdb_valid with data 0xDEADBEEF and the matching rob_idx/rd.
- LB: addr=0x2002, rdata=0x0080_0000 -> rmask=0100, cdb_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH: rs1=0x3000, imm=2, rs2=0x1234ABCD -> wmask=1100, wdata=0xABCD0000, rmask=0, then cdb_valid with phys_rd=0 and data=0.
- LW to 0x4001 -> no dmem mask ever asserted, cdb_valid with cdb_misaligned=1.
- flush during WAIT, resp 5 cycles later -> no cdb_valid, busy stays high until resp, lsq_read_en resumes the cycle after DRAIN exits.
- rst low mid-WAIT -> all outputs 0 immediately (asynchronous). After release, lsq_read_en=1 on the first clock; lsq_read_en is never high on two consecutive cycles across a 10-entry stream.

Source files
------------

// File: rtl/lsq_mem_ctrl_if.sv
// Signal bundle between lsq_mem_ctrl and its LSQ, data-memory port and CDB.
// The master modport is the controller's view; slave is the surrounding pipeline/memory.
interface lsq_mem_ctrl_if #(
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5
);
    logic              lsq_read_en;
    logic              lsq_valid;
    logic [6:0]        lsq_opcode;
    logic [2:0]        lsq_funct3;
    logic [31:0]       lsq_imm;
    logic [PREG_W-1:0] lsq_phys_rd;
    logic [ROB_W-1:0]  lsq_rob_idx;
    logic [31:0]       rs1_val;
    logic [31:0]       rs2_val;

    logic [31:0]       dmem_addr;
    logic [3:0]        dmem_rmask;
    logic [3:0]        dmem_wmask;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_resp;

    logic              cdb_valid;
    logic [PREG_W-1:0] cdb_phys_rd;
    logic [ROB_W-1:0]  cdb_rob_idx;
    logic [31:0]       cdb_data;
    logic              cdb_misaligned;

    modport master (
        output lsq_read_en,
        input  lsq_valid, lsq_opcode, lsq_funct3, lsq_imm, lsq_phys_rd, lsq_rob_idx,
        input  rs1_val, rs2_val,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        output cdb_valid, cdb_phys_rd, cdb_rob_idx, cdb_data, cdb_misaligned
    );

    modport slave (
        input  lsq_read_en,
        output lsq_valid, lsq_opcode, lsq_funct3, lsq_imm, lsq_phys_rd, lsq_rob_idx,
        output rs1_val, rs2_val,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        input  cdb_valid, cdb_phys_rd, cdb_rob_idx, cdb_data, cdb_misaligned
    );
endinterface

// File: rtl/lsq_mem_ctrl.sv
// Pops one LSQ entry at a time, runs a single dmem request/response for it and
// reports completion on the CDB; a flushed in-flight access is drained, never abandoned.
module lsq_mem_ctrl #(
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    lsq_mem_ctrl_if.master bus,
    output logic           busy
);
    localparam logic [6:0] OP_B_STORE = 7'b0100011;

    typedef enum logic [2:0] {IDLE, POLL, ISSUE, WAIT, DONE, DRAIN} state_t;
    state_t state_reg, state_next;

    logic              is_store_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        off_reg;
    logic [31:0]       addr_reg;
    logic [3:0]        mask_reg;
    logic [31:0]       wdata_reg;
    logic [PREG_W-1:0] phys_rd_reg;
    logic [ROB_W-1:0]  rob_idx_reg;
    logic [31:0]       data_reg;
    logic              misaligned_reg;

    logic [31:0] eff_addr;
    logic [1:0]  off;
    logic [3:0]  mask;
    logic        misaligned;
    logic        capture;
    logic        load_done;
    logic [31:0] rdata_shift;
    logic [31:0] load_data;

    assign eff_addr = bus.rs1_val + bus.lsq_imm;
    assign off      = eff_addr[1:0];

    // funct3[1:0] encodes the access size; unused size codes are treated as word.
    always_comb begin
        mask       = 4'b1111;
        misaligned = 1'b0;
        case (bus.lsq_funct3[1:0])
            2'b00: mask = 4'b0001 << off;
            2'b01: begin
                mask       = 4'b0011 << off;
                misaligned = off[0];
            end
            default: misaligned = (off != 2'b00);
        endcase
    end

    assign rdata_shift = bus.dmem_rdata >> {off_reg, 3'b000};

    always_comb begin
        case (funct3_reg)
            3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_data = {24'd0, rdata_shift[7:0]};
            3'b101:  load_data = {16'd0, rdata_shift[15:0]};
            default: load_data = rdata_shift;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        load_done  = 1'b0;
        case (state_reg)
            IDLE:  state_next = flush ? IDLE : POLL;
            POLL: begin
                if (flush || !bus.lsq_valid) begin
                    state_next = IDLE;
                end else begin
                    capture    = 1'b1;
                    state_next = misaligned ? DONE : ISSUE;
                end
            end
            // The request is already on the bus in ISSUE, so a flush must still wait it out.
            ISSUE: state_next = flush ? DRAIN : WAIT;
            WAIT: begin
                if (flush) begin
                    state_next = bus.dmem_resp ? IDLE : DRAIN;
                end else if (bus.dmem_resp) begin
                    load_done  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:  state_next = IDLE;
            DRAIN: state_next = bus.dmem_resp ? IDLE : DRAIN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            is_store_reg   <= 1'b0;
            funct3_reg     <= 3'd0;
            off_reg        <= 2'd0;
            addr_reg       <= 32'd0;
            mask_reg       <= 4'd0;
            wdata_reg      <= 32'd0;
            phys_rd_reg    <= '0;
            rob_idx_reg    <= '0;
            data_reg       <= 32'd0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                is_store_reg   <= (bus.lsq_opcode == OP_B_STORE);
                funct3_reg     <= bus.lsq_funct3;
                off_reg        <= off;
                addr_reg       <= {eff_addr[31:2], 2'b00};
                mask_reg       <= misaligned ? 4'd0 : mask;
                wdata_reg      <= bus.rs2_val << {off, 3'b000};
                phys_rd_reg    <= bus.lsq_phys_rd;
                rob_idx_reg    <= bus.lsq_rob_idx;
                data_reg       <= 32'd0;
                misaligned_reg <= misaligned;
            end else if (load_done && !is_store_reg) begin
                data_reg <= load_data;
            end
        end
    end

    // State is already IDLE while rst is low, so the pop request is masked by rst directly.
    always_comb begin
        bus.lsq_read_en    = rst && (state_reg == IDLE) && !flush;
        bus.dmem_addr      = 32'd0;
        bus.dmem_rmask     = 4'd0;
        bus.dmem_wmask     = 4'd0;
        bus.dmem_wdata     = 32'd0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_phys_rd    = '0;
        bus.cdb_rob_idx    = '0;
        bus.cdb_data       = 32'd0;
        bus.cdb_misaligned = 1'b0;
        if (state_reg == ISSUE) begin
            bus.dmem_addr = addr_reg;
            if (is_store_reg) begin
                bus.dmem_wmask = mask_reg;
                bus.dmem_wdata = wdata_reg;
            end else begin
                bus.dmem_rmask = mask_reg;
            end
        end
        if (state_reg == DONE && !flush) begin
            bus.cdb_valid      = 1'b1;
            bus.cdb_phys_rd    = is_store_reg ? '0 : phys_rd_reg;
            bus.cdb_rob_idx    = rob_idx_reg;
            bus.cdb_data       = data_reg;
            bus.cdb_misaligned = misaligned_reg;
        end
    end

    assign busy = (state_reg != IDLE);
endmodule

// File: tb/tb_lsq_mem_ctrl.sv
// Directed bench for lsq_mem_ctrl: expected CDB results are queued when an entry is
// handed to the controller and compared when cdb_valid appears.
module tb_lsq_mem_ctrl;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    lsq_mem_ctrl_if #(.PREG_W(6), .ROB_W(5)) bus ();

    lsq_mem_ctrl #(.PREG_W(6), .ROB_W(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  rd;
        logic [4:0]  rob;
        logic [31:0] data;
        logic        mis;
    } cdb_t;
    cdb_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The LSQ must never see a pop request on two consecutive cycles.
    logic prev_rd_en = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_rd_en = 1'b0;
        end else begin
            if (prev_rd_en) chk("no_double_pop", {31'd0, bus.lsq_read_en}, 32'd0);
            prev_rd_en = bus.lsq_read_en;
        end
    end

    task automatic wait_pop(input string tag);
        int waited = 0;
        while (!bus.lsq_read_en && waited < 20) begin
            tick();
            waited++;
        end
        chk({tag, "_pop"}, {31'd0, bus.lsq_read_en}, 32'd1);
    endtask

    task automatic drive_entry(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] rs1,
                               input logic [31:0] imm, input logic [31:0] rs2,
                               input logic [5:0] rd, input logic [4:0] rob);
        bus.lsq_valid   = 1'b1;
        bus.lsq_opcode  = op;
        bus.lsq_funct3  = f3;
        bus.rs1_val     = rs1;
        bus.lsq_imm     = imm;
        bus.rs2_val     = rs2;
        bus.lsq_phys_rd = rd;
        bus.lsq_rob_idx = rob;
    endtask

    task automatic do_txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                          input logic [5:0] rd, input logic [4:0] rob,
                          input logic [31:0] rdata, input int delay,
                          input logic [31:0] e_addr, input logic [3:0] e_mask,
                          input logic [31:0] e_wdata, input logic [31:0] e_data, input logic e_mis);
        int   n_issue = 0;
        int   cnt     = 0;
        bit   got     = 0;
        bit   st      = (op == OP_STORE);
        cdb_t e;
        wait_pop(tag);
        tick();
        drive_entry(op, f3, rs1, imm, rs2, rd, rob);
        e.rd   = st ? 6'd0 : rd;
        e.rob  = rob;
        e.data = e_data;
        e.mis  = e_mis;
        sb.push_back(e);
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            bus.lsq_valid = 1'b0;
            bus.dmem_resp = 1'b0;
            if (bus.dmem_rmask != 4'd0 || bus.dmem_wmask != 4'd0) begin
                n_issue++;
                chk({tag, "_addr"}, bus.dmem_addr, e_addr);
                chk({tag, "_rmask"}, {28'd0, bus.dmem_rmask}, st ? 32'd0 : {28'd0, e_mask});
                chk({tag, "_wmask"}, {28'd0, bus.dmem_wmask}, st ? {28'd0, e_mask} : 32'd0);
                if (st) chk({tag, "_wdata"}, bus.dmem_wdata, e_wdata);
                cnt = delay;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.dmem_resp  = 1'b1;
                    bus.dmem_rdata = rdata;
                end
            end
            if (bus.cdb_valid) begin
                got = 1;
                chk({tag, "_sb_nonempty"}, sb.size(), (sb.size() == 0) ? 32'd1 : sb.size());
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({tag, "_cdb_rd"}, {26'd0, bus.cdb_phys_rd}, {26'd0, e.rd});
                    chk({tag, "_cdb_rob"}, {27'd0, bus.cdb_rob_idx}, {27'd0, e.rob});
                    chk({tag, "_cdb_data"}, bus.cdb_data, e.data);
                    chk({tag, "_cdb_mis"}, {31'd0, bus.cdb_misaligned}, {31'd0, e.mis});
                end
            end
        end
        bus.dmem_resp = 1'b0;
        chk({tag, "_cdb_seen"}, {31'd0, got}, 32'd1);
        chk({tag, "_issues"}, n_issue, e_mis ? 32'd0 : 32'd1);
        tick();
        chk({tag, "_cdb_single"}, {31'd0, bus.cdb_valid}, 32'd0);
        $display("txn %s done: issues=%0d cdb=%0d", tag, n_issue, got);
    endtask

    initial begin
        bus.lsq_valid   = 1'b0;
        bus.lsq_opcode  = 7'd0;
        bus.lsq_funct3  = 3'd0;
        bus.lsq_imm     = 32'd0;
        bus.lsq_phys_rd = 6'd0;
        bus.lsq_rob_idx = 5'd0;
        bus.rs1_val     = 32'd0;
        bus.rs2_val     = 32'd0;
        bus.dmem_rdata  = 32'd0;
        bus.dmem_resp   = 1'b0;

        tick();
        tick();
        chk("reset_read_en", {31'd0, bus.lsq_read_en}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_cdb", {31'd0, bus.cdb_valid}, 32'd0);
        chk("reset_masks", {24'd0, bus.dmem_rmask, bus.dmem_wmask}, 32'd0);
        rst = 1'b1;
        #1;
        chk("release_read_en", {31'd0, bus.lsq_read_en}, 32'd1);
        $display("reset released");

        do_txn("lw",  OP_LOAD,  3'b010, 32'h1000, 32'd4, 32'd0, 6'd5, 5'd3, 32'hDEADBEEF, 3,
               32'h1004, 4'b1111, 32'd0, 32'hDEADBEEF, 1'b0);
        do_txn("lb",  OP_LOAD,  3'b000, 32'h2000, 32'd2, 32'd0, 6'd9, 5'd4, 32'h0080_0000, 2,
               32'h2000, 4'b0100, 32'd0, 32'hFFFFFF80, 1'b0);
        do_txn("lbu", OP_LOAD,  3'b100, 32'h2000, 32'd2, 32'd0, 6'd10, 5'd5, 32'h0080_0000, 1,
               32'h2000, 4'b0100, 32'd0, 32'h00000080, 1'b0);
        do_txn("sh",  OP_STORE, 3'b001, 32'h3000, 32'd2, 32'h1234ABCD, 6'd7, 5'd6, 32'd0, 2,
               32'h3000, 4'b1100, 32'hABCD0000, 32'd0, 1'b0);
        do_txn("lw_mis", OP_LOAD, 3'b010, 32'h4000, 32'd1, 32'd0, 6'd11, 5'd7, 32'd0, 1,
               32'd0, 4'd0, 32'd0, 32'd0, 1'b1);
        do_txn("lh",  OP_LOAD,  3'b001, 32'h5000, 32'd2, 32'd0, 6'd12, 5'd8, 32'h8001_1234, 1,
               32'h5000, 4'b1100, 32'd0, 32'hFFFF8001, 1'b0);
        do_txn("lhu", OP_LOAD,  3'b101, 32'h5010, 32'd0, 32'd0, 6'd13, 5'd9, 32'h1234_F00D, 2,
               32'h5010, 4'b0011, 32'd0, 32'h0000F00D, 1'b0);
        do_txn("sb",  OP_STORE, 3'b000, 32'h6000, 32'd3, 32'h123456AB, 6'd14, 5'd10, 32'd0, 1,
               32'h6000, 4'b1000, 32'hAB000000, 32'd0, 1'b0);
        do_txn("lw_negimm", OP_LOAD, 3'b010, 32'h5008, 32'hFFFFFFFC, 32'd0, 6'd15, 5'd11,
               32'hCAFEF00D, 1, 32'h5004, 4'b1111, 32'd0, 32'hCAFEF00D, 1'b0);
        do_txn("sh_mis", OP_STORE, 3'b001, 32'h7000, 32'd1, 32'hFFFF, 6'd16, 5'd12, 32'd0, 1,
               32'd0, 4'd0, 32'd0, 32'd0, 1'b1);

        // empty poll: no entry offered, controller returns to IDLE and asks again
        wait_pop("empty");
        tick();
        tick();
        chk("empty_repoll", {31'd0, bus.lsq_read_en}, 32'd1);
        chk("empty_busy", {31'd0, busy}, 32'd0);
        $display("empty poll done");

        // flush in POLL discards the offered entry
        wait_pop("flush_poll");
        tick();
        drive_entry(OP_LOAD, 3'b010, 32'h8000, 32'd0, 32'd0, 6'd17, 5'd13);
        flush = 1'b1;
        tick();
        bus.lsq_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_poll_busy", {31'd0, busy}, 32'd0);
        chk("flush_poll_mask", {28'd0, bus.dmem_rmask}, 32'd0);
        chk("flush_poll_cdb", {31'd0, bus.cdb_valid}, 32'd0);
        chk("flush_poll_read_en", {31'd0, bus.lsq_read_en}, 32'd1);
        $display("flush in POLL done");

        // flush in WAIT: drain until the response arrives 5 cycles later
        wait_pop("flush_wait");
        tick();
        drive_entry(OP_LOAD, 3'b010, 32'h9000, 32'd0, 32'd0, 6'd18, 5'd14);
        tick();
        bus.lsq_valid = 1'b0;
        chk("flush_wait_issue", {28'd0, bus.dmem_rmask}, 32'hF);
        tick();
        flush = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            flush = 1'b0;
            chk("drain_busy", {31'd0, busy}, 32'd1);
            chk("drain_cdb", {31'd0, bus.cdb_valid}, 32'd0);
            chk("drain_read_en", {31'd0, bus.lsq_read_en}, 32'd0);
            if (i == 5) begin
                bus.dmem_resp  = 1'b1;
                bus.dmem_rdata = 32'h5555AAAA;
            end
        end
        tick();
        bus.dmem_resp = 1'b0;
        chk("drain_exit_busy", {31'd0, busy}, 32'd0);
        chk("drain_exit_read_en", {31'd0, bus.lsq_read_en}, 32'd1);
        chk("drain_exit_cdb", {31'd0, bus.cdb_valid}, 32'd0);
        tick();
        chk("drain_no_late_cdb", {31'd0, bus.cdb_valid}, 32'd0);
        $display("flush in WAIT done");

        // asynchronous reset while waiting on dmem
        wait_pop("rst_wait");
        tick();
        drive_entry(OP_STORE, 3'b010, 32'hA000, 32'd0, 32'h11223344, 6'd19, 5'd15);
        tick();
        bus.lsq_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_ctrl", {29'd0, bus.lsq_read_en, bus.cdb_valid, bus.cdb_misaligned}, 32'd0);
        chk("async_rst_masks", {24'd0, bus.dmem_rmask, bus.dmem_wmask}, 32'd0);
        chk("async_rst_addr", bus.dmem_addr, 32'd0);
        chk("async_rst_wdata", bus.dmem_wdata, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rerelease_read_en", {31'd0, bus.lsq_read_en}, 32'd1);
        $display("async reset mid-WAIT done");

        // 10-entry stream of alternating word stores and loads
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            logic [31:0] v;
            a = 32'h100 + 32'(4 * i);
            v = 32'h11111111 * 32'(i + 1);
            if (i % 2 == 0)
                do_txn($sformatf("stream_sw%0d", i), OP_STORE, 3'b010, 32'h100, 32'(4 * i), v,
                       6'(20 + i), 5'(i), 32'd0, 1 + i % 3, a, 4'b1111, v, 32'd0, 1'b0);
            else
                do_txn($sformatf("stream_lw%0d", i), OP_LOAD, 3'b010, 32'h100, 32'(4 * i), 32'd0,
                       6'(20 + i), 5'(i), v, 1 + i % 3, a, 4'b1111, 32'd0, v, 1'b0);
        end

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
